// File: rtl/riscv_mem_pkg.sv
// Shared MEM-stage definitions for the load controller and the store formatter.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int WORD_OFFSET_BITS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } load_state_t;

    // Illegal load encodings are reported through the same path as misalignment.
    function automatic logic load_access_bad(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_LB, F3_LBU: return 1'b0;
            F3_LH, F3_LHU: return off[0];
            F3_LW:         return off != 2'b00;
            default:       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword/word from a cache word and sign/zero extends it.
module load_extend
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{offset, 3'b000} +: 8];
    assign half_sel = word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        result = word;
        case (func3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'h0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'h0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_data_controller.sv
// MEM-stage load controller: issues a word-aligned cache read, waits out misses,
// and returns the extended result with a one-cycle valid pulse.
//
//  state | meaning
//  IDLE  | waiting for load_req
//  REQ   | read strobe asserted, waiting for mem_busy to drop
//  DONE  | load_valid pulse cycle
//  ERR   | misaligned or timeout pulse cycle
module load_data_controller
    import riscv_mem_pkg::*;
#(
    parameter int MAX_WAIT  = 255,
    parameter int CNT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_req,
    input  logic [2:0]  func3,
    input  logic [31:0] address,
    output logic        mem_read,
    output logic [31:0] mem_address,
    input  logic        mem_busy,
    input  logic [31:0] mem_readdata,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        busy,
    output logic        misaligned,
    output logic        timeout
);

    localparam logic [CNT_WIDTH-1:0] WAIT_LAST = CNT_WIDTH'(MAX_WAIT - 1);

    load_state_t          state;
    logic [2:0]           func3_q;
    logic [31:0]          addr_q;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic [31:0]          ext_word;

    load_extend u_extend (
        .func3  (func3_q),
        .offset (addr_q[WORD_OFFSET_BITS-1:0]),
        .word   (mem_readdata),
        .result (ext_word)
    );

    // addr_q only changes at acceptance, so the cache address is stable through REQ.
    assign mem_address = {addr_q[31:WORD_OFFSET_BITS], {WORD_OFFSET_BITS{1'b0}}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            func3_q    <= 3'b000;
            addr_q     <= 32'h0;
            wait_cnt   <= '0;
            mem_read   <= 1'b0;
            load_data  <= 32'h0;
            load_valid <= 1'b0;
            busy       <= 1'b0;
            misaligned <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            misaligned <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_req) begin
                        func3_q <= func3;
                        addr_q  <= address;
                        busy    <= 1'b1;
                        if (load_access_bad(func3, address[WORD_OFFSET_BITS-1:0])) begin
                            misaligned <= 1'b1;
                            state      <= ERR;
                        end else begin
                            wait_cnt <= '0;
                            mem_read <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (!mem_busy) begin
                        load_data  <= ext_word;
                        load_valid <= 1'b1;
                        mem_read   <= 1'b0;
                        state      <= DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout  <= 1'b1;
                        mem_read <= 1'b0;
                        state    <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE, ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_read <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_data_controller.sv
// Directed vector bench for load_data_controller (MAX_WAIT reduced to 8).
module tb_load_data_controller;
    import riscv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_req;
    logic [2:0]  func3;
    logic [31:0] address;
    logic        mem_read;
    logic [31:0] mem_address;
    logic        mem_busy;
    logic [31:0] mem_readdata;
    logic [31:0] load_data;
    logic        load_valid;
    logic        busy;
    logic        misaligned;
    logic        timeout;

    int n_tests = 0;
    int n_fail  = 0;

    load_data_controller #(.MAX_WAIT(8), .CNT_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_req     (load_req),
        .func3        (func3),
        .address      (address),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_busy     (mem_busy),
        .mem_readdata (mem_readdata),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .busy         (busy),
        .misaligned   (misaligned),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // kind: 0 = valid result, 1 = misaligned/illegal, 2 = timeout
    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] word;
        int          nbusy;
        int          kind;
        logic [31:0] data;
        int          lat;
        int          mrd;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, output int lat, output int mrd, output logic [2:0] code,
                           output logic stall_ok, output logic addr_ok, output logic idle_ok);
        int r;
        lat = 0; mrd = 0; code = 3'b000; stall_ok = 1'b1; addr_ok = 1'b1; r = 0;
        load_req = 1'b1; func3 = v.f3; address = v.addr; mem_readdata = v.word;
        mem_busy = (v.nbusy > 0);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            load_req = 1'b0;
            address  = 32'hFFFF_FFFF;
            if (busy !== 1'b1) stall_ok = 1'b0;
            if (mem_read === 1'b1) begin
                mrd++;
                r++;
                if (mem_address !== {v.addr[31:2], 2'b00}) addr_ok = 1'b0;
            end
            mem_busy = (mem_read === 1'b1) && (r <= v.nbusy);
            if ({timeout, misaligned, load_valid} !== 3'b000) begin
                code = {timeout, misaligned, load_valid};
                lat  = k;
                break;
            end
        end
        mem_busy = 1'b0;
        @(posedge clk); #1;
        idle_ok = (busy === 1'b0) && (mem_read === 1'b0);
    endtask

    initial begin
        logic [31:0] last_data;
        logic [2:0]  exp_code;
        int          lat, mrd;
        logic [2:0]  code;
        logic        stall_ok, addr_ok, idle_ok;

        vecs[0]  = '{F3_LW,  32'h0000_0100, 32'hDEAD_BEEF, 0,   0, 32'hDEAD_BEEF, 2, 1};
        vecs[1]  = '{F3_LB,  32'h0000_0203, 32'h80FF_1234, 0,   0, 32'hFFFF_FF80, 2, 1};
        vecs[2]  = '{F3_LBU, 32'h0000_0203, 32'h80FF_1234, 0,   0, 32'h0000_0080, 2, 1};
        vecs[3]  = '{F3_LH,  32'h0000_0202, 32'h80FF_1234, 0,   0, 32'hFFFF_80FF, 2, 1};
        vecs[4]  = '{F3_LHU, 32'h0000_0202, 32'h80FF_1234, 0,   0, 32'h0000_80FF, 2, 1};
        vecs[5]  = '{F3_LB,  32'h0000_0200, 32'h80FF_1234, 0,   0, 32'h0000_0034, 2, 1};
        vecs[6]  = '{F3_LB,  32'h0000_0202, 32'h80FF_1234, 0,   0, 32'hFFFF_FFFF, 2, 1};
        vecs[7]  = '{F3_LBU, 32'h0000_0201, 32'h80FF_1234, 0,   0, 32'h0000_0012, 2, 1};
        vecs[8]  = '{F3_LH,  32'h0000_0200, 32'h80FF_1234, 0,   0, 32'h0000_1234, 2, 1};
        vecs[9]  = '{F3_LW,  32'h0000_0300, 32'h0BAD_F00D, 5,   0, 32'h0BAD_F00D, 7, 6};
        vecs[10] = '{F3_LH,  32'h0000_0101, 32'h1111_1111, 0,   1, 32'h0,         1, 0};
        vecs[11] = '{F3_LW,  32'h0000_0102, 32'h1111_1111, 0,   1, 32'h0,         1, 0};
        vecs[12] = '{3'b011, 32'h0000_0100, 32'h1111_1111, 0,   1, 32'h0,         1, 0};
        vecs[13] = '{3'b110, 32'h0000_0104, 32'h1111_1111, 0,   1, 32'h0,         1, 0};
        vecs[14] = '{3'b111, 32'h0000_0108, 32'h1111_1111, 0,   1, 32'h0,         1, 0};
        vecs[15] = '{F3_LHU, 32'h0000_0103, 32'h1111_1111, 0,   1, 32'h0,         1, 0};
        vecs[16] = '{F3_LW,  32'h0000_0400, 32'h1111_1111, 100, 2, 32'h0,         9, 8};
        vecs[17] = '{F3_LW,  32'h0000_0404, 32'h7654_3210, 0,   0, 32'h7654_3210, 2, 1};
        vecs[18] = '{F3_LHU, 32'h0000_040E, 32'hA5B6_C7D8, 2,   0, 32'h0000_A5B6, 4, 3};
        vecs[19] = '{F3_LH,  32'h7FFF_FFFC, 32'h0000_8001, 1,   0, 32'hFFFF_8001, 3, 2};

        // Reset with a request pending: reset must win.
        reset = 1'b1; load_req = 1'b1; func3 = F3_LW; address = 32'h0000_0100;
        mem_busy = 1'b0; mem_readdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_read",    {31'h0, mem_read},   32'h0);
        chk("rst_mem_address", mem_address,         32'h0);
        chk("rst_load_data",   load_data,           32'h0);
        chk("rst_load_valid",  {31'h0, load_valid}, 32'h0);
        chk("rst_busy",        {31'h0, busy},       32'h0);
        chk("rst_misaligned",  {31'h0, misaligned}, 32'h0);
        chk("rst_timeout",     {31'h0, timeout},    32'h0);
        reset = 1'b0; load_req = 1'b0;
        @(posedge clk); #1;

        last_data = 32'h0;
        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], lat, mrd, code, stall_ok, addr_ok, idle_ok);
            if (vecs[i].kind == 0) last_data = vecs[i].data;
            exp_code = (vecs[i].kind == 0) ? 3'b001 : (vecs[i].kind == 1) ? 3'b010 : 3'b100;
            chk($sformatf("v%0d_pulse", i),    {29'h0, code},     {29'h0, exp_code});
            chk($sformatf("v%0d_latency", i),  lat,               vecs[i].lat);
            chk($sformatf("v%0d_mem_read", i), mrd,               vecs[i].mrd);
            chk($sformatf("v%0d_data", i),     load_data,         last_data);
            chk($sformatf("v%0d_busy", i),     {31'h0, stall_ok}, 32'h1);
            chk($sformatf("v%0d_addr", i),     {31'h0, addr_ok},  32'h1);
            chk($sformatf("v%0d_idle", i),     {31'h0, idle_ok},  32'h1);
        end

        // Reset during the third busy cycle of a stalled load, request held across reset.
        load_req = 1'b1; func3 = F3_LW; address = 32'h0000_0500;
        mem_readdata = 32'h1234_5678; mem_busy = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_in_req", {31'h0, mem_read}, 32'h1);
        reset = 1'b1; load_req = 1'b1; address = 32'h0000_0600;
        mem_readdata = 32'hCAFE_F00D; mem_busy = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy",      {31'h0, busy},       32'h0);
        chk("mid_rst_mem_read",  {31'h0, mem_read},   32'h0);
        chk("mid_rst_load_data", load_data,           32'h0);
        chk("mid_rst_pulses",    {29'h0, timeout, misaligned, load_valid}, 32'h0);
        @(posedge clk); #1;
        chk("mid_rst_req_dropped", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_accept", {30'h0, busy, mem_read}, 32'h3);
        chk("post_rst_addr",   mem_address,             32'h0000_0600);
        load_req = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_valid", {31'h0, load_valid}, 32'h1);
        chk("post_rst_data",  load_data,           32'hCAFE_F00D);
        @(posedge clk); #1;
        chk("post_rst_idle", {31'h0, busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
